// File: rtl/axis_mstr_mux.sv
// User-project to AS AXI-Stream master mux: packet-boundary source switching, 2-entry output skid buffer.
// Define AXIS_MSTR_MUX_PKT_CNT_EN to add the completed-packet counter (pkt_cnt / pkt_cnt_clr).
module axis_mstr_mux #(
    parameter int pCH_NUM                      = 4,
    parameter int pDATA_WIDTH                  = 32,
    parameter int pUSER_PROJECT_SIDEBAND_WIDTH = 5
) (
    input  logic                                            axis_clk,
    input  logic                                            axis_rst,
    input  logic [4:0]                                      user_prj_sel,
    input  logic [pCH_NUM-1:0]                              sm_tvalid,
    output logic [pCH_NUM-1:0]                              sm_tready,
    input  logic [pCH_NUM*pDATA_WIDTH-1:0]                  sm_tdata,
    input  logic [pCH_NUM*pUSER_PROJECT_SIDEBAND_WIDTH-1:0] sm_tupsb,
    input  logic [pCH_NUM*(pDATA_WIDTH/8)-1:0]              sm_tstrb,
    input  logic [pCH_NUM*(pDATA_WIDTH/8)-1:0]              sm_tkeep,
    input  logic [pCH_NUM-1:0]                              sm_tlast,
    output logic                                            m_tvalid,
    input  logic                                            m_tready,
    output logic [pDATA_WIDTH-1:0]                          m_tdata,
    output logic [pUSER_PROJECT_SIDEBAND_WIDTH-1:0]         m_tupsb,
    output logic [pDATA_WIDTH/8-1:0]                        m_tstrb,
    output logic [pDATA_WIDTH/8-1:0]                        m_tkeep,
    output logic                                            m_tlast,
    output logic [1:0]                                      m_tuser,
    output logic                                            busy
`ifdef AXIS_MSTR_MUX_PKT_CNT_EN
    ,
    input  logic                                            pkt_cnt_clr,
    output logic [15:0]                                     pkt_cnt
`endif
);

    localparam int SW = pDATA_WIDTH / 8;
    localparam int UW = pUSER_PROJECT_SIDEBAND_WIDTH;

    typedef struct packed {
        logic [pDATA_WIDTH-1:0] data;
        logic [UW-1:0]          upsb;
        logic [SW-1:0]          strb;
        logic [SW-1:0]          keep;
        logic                   last;
    } beat_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [4:0]         active_sel_r;
    logic [4:0]         active_sel_nxt_s;
    logic [pCH_NUM-1:0] ch_hit_s;
    logic               in_rdy_s;
    logic               sel_valid_s;
    logic               accept_s;
    beat_t              sel_beat_s;
    beat_t              main_r;
    beat_t              skid_r;
    logic               main_valid_r;
    logic               skid_valid_r;

    // One-hot decode of active_sel; all zero when the index is out of range
    always_comb begin
        for (int i = 0; i < pCH_NUM; i++) begin
            ch_hit_s[i] = (active_sel_r == 5'(i));
        end
    end

    // AND-OR gather of the selected channel's beat
    always_comb begin
        sel_valid_s = 1'b0;
        sel_beat_s  = '0;
        for (int i = 0; i < pCH_NUM; i++) begin
            sel_valid_s     = sel_valid_s | (sm_tvalid[i] & ch_hit_s[i]);
            sel_beat_s.data = sel_beat_s.data | (sm_tdata[i*pDATA_WIDTH +: pDATA_WIDTH] & {pDATA_WIDTH{ch_hit_s[i]}});
            sel_beat_s.upsb = sel_beat_s.upsb | (sm_tupsb[i*UW +: UW] & {UW{ch_hit_s[i]}});
            sel_beat_s.strb = sel_beat_s.strb | (sm_tstrb[i*SW +: SW] & {SW{ch_hit_s[i]}});
            sel_beat_s.keep = sel_beat_s.keep | (sm_tkeep[i*SW +: SW] & {SW{ch_hit_s[i]}});
            sel_beat_s.last = sel_beat_s.last | (sm_tlast[i] & ch_hit_s[i]);
        end
    end

    // Input side is ready only while the skid register is free
    assign in_rdy_s  = ~skid_valid_r;
    assign sm_tready = ch_hit_s & {pCH_NUM{in_rdy_s & ~axis_rst}};
    assign accept_s  = sel_valid_s & in_rdy_s & ~axis_rst;

    // Packet-boundary selection: source may only change while idle
    always_comb begin
        state_nxt_s      = state_r;
        active_sel_nxt_s = active_sel_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !sel_beat_s.last) begin
                    state_nxt_s = ST_PKT;
                end else begin
                    active_sel_nxt_s = user_prj_sel;
                end
            end
            ST_PKT: begin
                if (accept_s && sel_beat_s.last) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_PKT;
                end
            end
            default: begin
                state_nxt_s      = ST_IDLE;
                active_sel_nxt_s = 5'd0;
            end
        endcase
    end

    // State and selection registers
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_r      <= ST_IDLE;
            active_sel_r <= 5'd0;
        end else begin
            state_r      <= state_nxt_s;
            active_sel_r <= active_sel_nxt_s;
        end
    end

    // Output register plus skid: skid drains first so beat order is preserved
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            main_valid_r <= 1'b0;
            main_r       <= '0;
            skid_valid_r <= 1'b0;
            skid_r       <= '0;
        end else if (!main_valid_r || m_tready) begin
            if (skid_valid_r) begin
                main_r       <= skid_r;
                main_valid_r <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                main_r       <= sel_beat_s;
                main_valid_r <= 1'b1;
            end else begin
                main_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            skid_r       <= sel_beat_s;
            skid_valid_r <= 1'b1;
        end
    end

    assign m_tvalid = main_valid_r;
    assign m_tdata  = main_r.data;
    assign m_tupsb  = main_r.upsb;
    assign m_tstrb  = main_r.strb;
    assign m_tkeep  = main_r.keep;
    assign m_tlast  = main_r.last;
    assign m_tuser  = 2'b00;
    assign busy     = (state_r == ST_PKT);

`ifdef AXIS_MSTR_MUX_PKT_CNT_EN
    logic [15:0] pkt_cnt_r;

    // Completed-packet counter; clear wins over a same-cycle completion
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            pkt_cnt_r <= 16'd0;
        end else if (pkt_cnt_clr) begin
            pkt_cnt_r <= 16'd0;
        end else if (main_valid_r && m_tready && main_r.last) begin
            pkt_cnt_r <= pkt_cnt_r + 16'd1;
        end
    end

    assign pkt_cnt = pkt_cnt_r;
`endif

endmodule

// File: tb/tb_axis_mstr_mux.sv
// Bench for axis_mstr_mux: vector table, hand-written corner sequences, randomized run against a queue model.
module tb_axis_mstr_mux;

    logic              axis_clk = 1'b0;
    logic              axis_rst;
    logic [4:0]        user_prj_sel;
    logic [3:0]        sm_tvalid;
    logic [3:0]        sm_tready;
    logic [3:0][31:0]  ch_data;
    logic [127:0]      sm_tdata;
    logic [19:0]       sm_tupsb;
    logic [15:0]       sm_tstrb;
    logic [15:0]       sm_tkeep;
    logic [3:0]        sm_tlast;
    logic              m_tvalid;
    logic              m_tready;
    logic [31:0]       m_tdata;
    logic [4:0]        m_tupsb;
    logic [3:0]        m_tstrb;
    logic [3:0]        m_tkeep;
    logic              m_tlast;
    logic [1:0]        m_tuser;
    logic              busy;
`ifdef AXIS_MSTR_MUX_PKT_CNT_EN
    logic              pkt_cnt_clr;
    logic [15:0]       pkt_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 axis_clk = ~axis_clk;

    // Sideband fields are derived from each channel's data so they can be predicted
    assign sm_tdata = ch_data;
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sm_tupsb[i*5 +: 5] = ch_data[i][4:0];
            sm_tstrb[i*4 +: 4] = ch_data[i][7:4];
            sm_tkeep[i*4 +: 4] = ch_data[i][11:8];
        end
    end

    axis_mstr_mux #(
        .pCH_NUM(4), .pDATA_WIDTH(32), .pUSER_PROJECT_SIDEBAND_WIDTH(5)
    ) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst), .user_prj_sel(user_prj_sel),
        .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata),
        .sm_tupsb(sm_tupsb), .sm_tstrb(sm_tstrb), .sm_tkeep(sm_tkeep), .sm_tlast(sm_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tupsb(m_tupsb),
        .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .busy(busy)
`ifdef AXIS_MSTR_MUX_PKT_CNT_EN
        , .pkt_cnt_clr(pkt_cnt_clr), .pkt_cnt(pkt_cnt)
`endif
    );

    typedef struct {
        logic       rst;
        logic [4:0] sel;
        logic [3:0] tv;
        logic [3:0] tl;
        logic       mr;
        logic [3:0] e_rdy;
        logic       e_mv;
        logic       e_busy;
        logic [3:0] e_ch;
    } vec_t;
    vec_t tbl[14];

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } mbeat_t;
    mbeat_t      mq[$];
    logic [4:0]  msel;
    logic        mpkt;
    logic        macc;
    logic        mlst;
    logic [3:0]  exp_rdy;
    logic [15:0] mcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic do_reset();
        axis_rst  = 1'b1;
        sm_tvalid = 4'b0000;
        sm_tlast  = 4'b0000;
        tick();
        tick();
        axis_rst  = 1'b0;
    endtask

    initial begin
        axis_rst     = 1'b1;
        user_prj_sel = 5'd0;
        sm_tvalid    = 4'b0000;
        sm_tlast     = 4'b0000;
        m_tready     = 1'b0;
        ch_data      = '0;
`ifdef AXIS_MSTR_MUX_PKT_CNT_EN
        pkt_cnt_clr  = 1'b0;
`endif
        //          rst   sel    tv     tl     mr    e_rdy  e_mv  e_busy e_ch
        tbl[0]  = '{1'b0, 5'd7, 4'h0, 4'h0, 1'b1, 4'b0001, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 5'd7, 4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b0, 5'd7, 4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0};
        tbl[3]  = '{1'b0, 5'd4, 4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0};
        tbl[4]  = '{1'b0, 5'd0, 4'hF, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0};
        tbl[5]  = '{1'b0, 5'd0, 4'hF, 4'hF, 1'b1, 4'b0001, 1'b0, 1'b0, 4'd0};
        tbl[6]  = '{1'b0, 5'd0, 4'h0, 4'h0, 1'b1, 4'b0001, 1'b1, 1'b0, 4'd0};
        tbl[7]  = '{1'b0, 5'd0, 4'h0, 4'h0, 1'b1, 4'b0001, 1'b0, 1'b0, 4'd0};
        tbl[8]  = '{1'b1, 5'd2, 4'hF, 4'h0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'd0};
        tbl[9]  = '{1'b0, 5'd2, 4'h0, 4'h0, 1'b1, 4'b0001, 1'b0, 1'b0, 4'd0};
        tbl[10] = '{1'b0, 5'd2, 4'h4, 4'h0, 1'b1, 4'b0100, 1'b0, 1'b0, 4'd0};
        tbl[11] = '{1'b0, 5'd2, 4'h0, 4'h0, 1'b1, 4'b0100, 1'b1, 1'b1, 4'd2};
        tbl[12] = '{1'b1, 5'd2, 4'h0, 4'h0, 1'b1, 4'b0000, 1'b0, 1'b1, 4'd0};
        tbl[13] = '{1'b0, 5'd2, 4'h0, 4'h0, 1'b1, 4'b0001, 1'b0, 1'b0, 4'd0};

        // Reset state
        tick();
        @(negedge axis_clk);
        chk("rst_rdy", sm_tready, 4'b0000);
        chk("rst_mvalid", m_tvalid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", {m_tdata, m_tupsb, m_tstrb, m_tkeep, m_tlast}, 64'd0);
        chk("rst_tuser", m_tuser, 2'b00);
`ifdef AXIS_MSTR_MUX_PKT_CNT_EN
        chk("rst_cnt", pkt_cnt, 16'd0);
`endif

        // Vector table: out-of-range select, single beats, reset in PKT
        do_reset();
        for (int i = 0; i < 4; i++) ch_data[i] = 32'hC0DE_0000 + 32'(i);
        for (int r = 0; r < 14; r++) begin
            axis_rst     = tbl[r].rst;
            user_prj_sel = tbl[r].sel;
            sm_tvalid    = tbl[r].tv;
            sm_tlast     = tbl[r].tl;
            m_tready     = tbl[r].mr;
            @(negedge axis_clk);
            chk("tbl_rdy", sm_tready, tbl[r].e_rdy);
            chk("tbl_mvalid", m_tvalid, tbl[r].e_mv);
            chk("tbl_busy", busy, tbl[r].e_busy);
            chk("tbl_tuser", m_tuser, 2'b00);
            if (tbl[r].e_mv) chk("tbl_data", m_tdata, 32'hC0DE_0000 + 32'(tbl[r].e_ch));
            tick();
        end
        axis_rst = 1'b0;

        // Back-to-back 4-beat packet on channel 2
        do_reset();
        m_tready = 1'b1;
        user_prj_sel = 5'd2;
        for (int i = 0; i < 4; i++) ch_data[i] = 32'hDEAD_0000 + 32'(i);
        tick();
        sm_tvalid = 4'b1111;
        sm_tlast  = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            ch_data[2]  = 32'h0000_0AA0 + 32'(k);
            sm_tlast[2] = (k == 3);
            @(negedge axis_clk);
            chk("b2b_rdy", sm_tready, 4'b0100);
            if (k > 0) begin
                chk("b2b_mvalid", m_tvalid, 1'b1);
                chk("b2b_data", m_tdata, 32'h0000_0AA0 + 32'(k - 1));
                chk("b2b_busy", busy, 1'b1);
                chk("b2b_last", m_tlast, 1'b0);
            end
            if (k == 2) chk("b2b_side", {m_tupsb, m_tstrb, m_tkeep}, {5'h01, 4'hA, 4'hA});
            tick();
        end
        sm_tvalid[2] = 1'b0;
        @(negedge axis_clk);
        chk("b2b_data3", m_tdata, 32'h0000_0AA3);
        chk("b2b_last3", m_tlast, 1'b1);
        chk("b2b_idle", busy, 1'b0);
        tick();
        @(negedge axis_clk);
        chk("b2b_drain", m_tvalid, 1'b0);

        // Backpressure on channel 0
        do_reset();
        user_prj_sel = 5'd0;
        m_tready = 1'b0;
        ch_data[0] = 32'h11; sm_tvalid = 4'b1111; sm_tlast = 4'b1110;
        @(negedge axis_clk);
        chk("bp_rdy1", sm_tready, 4'b0001);
        tick();
        ch_data[0] = 32'h22;
        @(negedge axis_clk);
        chk("bp_rdy2", sm_tready, 4'b0001);
        chk("bp_data1", m_tdata, 32'h11);
        tick();
        ch_data[0] = 32'h33; sm_tlast[0] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge axis_clk);
            chk("bp_full", sm_tready, 4'b0000);
            chk("bp_hold", {m_tvalid, m_tdata}, {1'b1, 32'h11});
            tick();
        end
        m_tready = 1'b1;
        @(negedge axis_clk);
        chk("bp_out1", m_tdata, 32'h11);
        chk("bp_rdy_rel", sm_tready, 4'b0000);
        tick();
        @(negedge axis_clk);
        chk("bp_out2", m_tdata, 32'h22);
        chk("bp_rdy_back", sm_tready, 4'b0001);
        tick();
        sm_tvalid[0] = 1'b0;
        @(negedge axis_clk);
        chk("bp_out3", {m_tvalid, m_tdata, m_tlast}, {1'b1, 32'h33, 1'b1});
        tick();
        @(negedge axis_clk);
        chk("bp_empty", m_tvalid, 1'b0);

        // Select change mid-packet is ignored until tlast
        do_reset();
        user_prj_sel = 5'd1;
        m_tready = 1'b1;
        tick();
        ch_data[3] = 32'hC0; sm_tvalid = 4'b1010; sm_tlast = 4'b1000;
        ch_data[1] = 32'hB0;
        @(negedge axis_clk);
        chk("sc_rdy0", sm_tready, 4'b0010);
        tick();
        user_prj_sel = 5'd3;
        ch_data[1] = 32'hB1;
        @(negedge axis_clk);
        chk("sc_rdy1", sm_tready, 4'b0010);
        chk("sc_busy1", busy, 1'b1);
        chk("sc_data0", m_tdata, 32'hB0);
        tick();
        ch_data[1] = 32'hB2; sm_tlast[1] = 1'b1;
        @(negedge axis_clk);
        chk("sc_rdy2", sm_tready, 4'b0010);
        chk("sc_busy2", busy, 1'b1);
        chk("sc_data1", m_tdata, 32'hB1);
        tick();
        sm_tvalid[1] = 1'b0;
        @(negedge axis_clk);
        chk("sc_busy3", busy, 1'b0);
        chk("sc_data2", {m_tdata, m_tlast}, {32'hB2, 1'b1});
        tick();
        @(negedge axis_clk);
        chk("sc_newsel", sm_tready, 4'b1000);
        tick();
        @(negedge axis_clk);
        chk("sc_ch3", {m_tvalid, m_tdata}, {1'b1, 32'hC0});

        // Reset mid-packet with a beat in the skid
        do_reset();
        user_prj_sel = 5'd1;
        tick();
        m_tready = 1'b0;
        ch_data[1] = 32'hD0; sm_tvalid = 4'b0010; sm_tlast = 4'b0000;
        @(negedge axis_clk);
        chk("rm_rdy0", sm_tready, 4'b0010);
        tick();
        ch_data[1] = 32'hD1;
        @(negedge axis_clk);
        chk("rm_mvalid", m_tvalid, 1'b1);
        tick();
        axis_rst = 1'b1; user_prj_sel = 5'd2; ch_data[1] = 32'hD2;
        @(negedge axis_clk);
        chk("rm_rdy_rst", sm_tready, 4'b0000);
        tick();
        axis_rst = 1'b0;
        @(negedge axis_clk);
        chk("rm_after", {m_tvalid, busy, m_tdata}, {1'b0, 1'b0, 32'h0});
        chk("rm_sel0", sm_tready, 4'b0001);
        tick();
        m_tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge axis_clk);
            chk("rm_no_old", m_tvalid, 1'b0);
            chk("rm_rdy2", sm_tready, 4'b0100);
            tick();
        end

`ifdef AXIS_MSTR_MUX_PKT_CNT_EN
        // Packet counter and clear-over-increment priority
        do_reset();
        user_prj_sel = 5'd0; m_tready = 1'b1;
        ch_data[0] = 32'h77; sm_tvalid = 4'b0001; sm_tlast = 4'b0001;
        tick(); tick(); tick();
        sm_tvalid = 4'b0000;
        tick();
        @(negedge axis_clk);
        chk("cnt_3", pkt_cnt, 16'd3);
        sm_tvalid = 4'b0001;
        tick();
        sm_tvalid = 4'b0000; pkt_cnt_clr = 1'b1;
        @(negedge axis_clk);
        chk("cnt_4th", {m_tvalid, m_tlast}, 2'b11);
        tick();
        pkt_cnt_clr = 1'b0;
        @(negedge axis_clk);
        chk("cnt_clr", pkt_cnt, 16'd0);
`endif

        // Randomized run against a queue-based reference
        do_reset();
        mq.delete(); msel = 5'd0; mpkt = 1'b0; mcnt = 16'd0;
        for (int c = 0; c < 3000; c++) begin
            axis_rst     = ($urandom_range(0, 99) == 0);
            user_prj_sel = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(4, 31)) : 5'($urandom_range(0, 3));
            sm_tvalid    = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                sm_tlast[i] = ($urandom_range(0, 3) == 0);
                ch_data[i]  = $urandom;
            end
            m_tready = ($urandom_range(0, 9) < 7);
`ifdef AXIS_MSTR_MUX_PKT_CNT_EN
            pkt_cnt_clr = ($urandom_range(0, 49) == 0);
`endif
            @(negedge axis_clk);
            exp_rdy = (!axis_rst && msel < 5'd4 && mq.size() < 2) ? (4'b0001 << msel) : 4'b0000;
            chk("rnd_rdy", sm_tready, exp_rdy);
            chk("rnd_mvalid", m_tvalid, mq.size() > 0);
            chk("rnd_busy", busy, mpkt);
            if (mq.size() > 0) begin
                chk("rnd_data", {m_tdata, m_tlast}, {mq[0].data, mq[0].last});
                chk("rnd_side", {m_tupsb, m_tstrb, m_tkeep}, {mq[0].data[4:0], mq[0].data[7:4], mq[0].data[11:8]});
            end
`ifdef AXIS_MSTR_MUX_PKT_CNT_EN
            chk("rnd_cnt", pkt_cnt, mcnt);
            if (axis_rst || pkt_cnt_clr) mcnt = 16'd0;
            else if (mq.size() > 0 && m_tready && mq[0].last) mcnt = mcnt + 16'd1;
`endif
            if (axis_rst) begin
                mq.delete(); msel = 5'd0; mpkt = 1'b0;
            end else begin
                macc = 1'b0; mlst = 1'b0;
                if (msel < 5'd4 && mq.size() < 2 && sm_tvalid[msel[1:0]]) begin
                    macc = 1'b1;
                    mlst = sm_tlast[msel[1:0]];
                end
                if (mq.size() > 0 && m_tready) void'(mq.pop_front());
                if (macc) mq.push_back({ch_data[msel[1:0]], mlst});
                if (!mpkt) begin
                    if (macc && !mlst) mpkt = 1'b1;
                    else msel = user_prj_sel;
                end else if (macc && mlst) begin
                    mpkt = 1'b0;
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_mstr_mux.md
Name: axis_mstr_mux

Overview:
- Next-generation user-project-to-AS AXI-Stream master mux, parametrised in channel count and widths.
- Selects one of pCH_NUM user-project stream sources by user_prj_sel and forwards it to a single AXIS master port.
- Selection switches only on packet boundaries, so a packet is never split.
- Per-channel tready goes to the selected source only; the output is registered through a 2-entry skid buffer for full throughput.

Parameters:
- pCH_NUM, 4, number of user-project source channels (1..32).
- pDATA_WIDTH, 32, tdata width; tstrb/tkeep width is pDATA_WIDTH/8.
- pUSER_PROJECT_SIDEBAND_WIDTH, 5, user-project sideband (tupsb) width.

Ports:
- axis_clk  in  1  clock; all logic rising-edge.
- axis_rst  in  1  synchronous, active-high reset.
- user_prj_sel  in  5  requested source channel index.
- sm_tvalid  in  pCH_NUM  per-channel valid.
- sm_tready  out  pCH_NUM  per-channel ready.
- sm_tdata  in  pCH_NUM*pDATA_WIDTH  channel i at [i*pDATA_WIDTH +: pDATA_WIDTH].
- sm_tupsb  in  pCH_NUM*pUSER_PROJECT_SIDEBAND_WIDTH  packed per channel.
- sm_tstrb  in  pCH_NUM*pDATA_WIDTH/8  packed per channel.
- sm_tkeep  in  pCH_NUM*pDATA_WIDTH/8  packed per channel.
- sm_tlast  in  pCH_NUM  per-channel last.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tdata  out  pDATA_WIDTH.
- m_tupsb  out  pUSER_PROJECT_SIDEBAND_WIDTH.
- m_tstrb  out  pDATA_WIDTH/8.
- m_tkeep  out  pDATA_WIDTH/8.
- m_tlast  out  1.
- m_tuser  out  2  constant 2'b00.
- busy  out  1  high while a packet is in progress (state PKT).

Behaviour:
- Reset (axis_rst=1 at a clock edge), all synchronous:
  - m_tvalid=0; m_tdata, m_tupsb, m_tstrb, m_tkeep and m_tlast are 0.
  - Skid entry cleared; busy=0; state=IDLE; active_sel=0; sm_tready=0 during reset.
  - Reset mid-packet discards buffered beats and any partial packet without emitting tlast.
- Selection:
  - active_sel is a registered 5-bit value.
  - In IDLE, active_sel <= user_prj_sel every cycle, except when a beat with tlast=0 is accepted that cycle. In that case active_sel holds and the state moves to PKT.
  - In PKT, active_sel is frozen and user_prj_sel changes are ignored.
  - When the tlast=1 beat is accepted, the state returns to IDLE; the new user_prj_sel is sampled from the next cycle.
  - active_sel >= pCH_NUM: no channel is selected, sm_tready is all 0, and no beats are accepted.
- Input handshake:
  - in_rdy = ~skid_valid.
  - sm_tready[i] = in_rdy & (active_sel==i) & ~axis_rst; non-selected channels see 0.
  - A beat is accepted when sm_tvalid[active_sel] & sm_tready[active_sel].
- Skid buffer (main output register plus skid register):
  - Accepted beat, main empty or m_tready=1: load main.
  - Accepted beat, main valid and m_tready=0: load skid.
  - When main is consumed and skid is valid, skid moves to main and skid clears.
  - Latency: accepted at edge N, visible on m_* after edge N, i.e. during cycle N+1.
  - Throughput is 1 beat/cycle with m_tready held high.
  - m_* is stable while m_tvalid=1 and m_tready=0 (AXIS rule); at most 2 beats are in flight.
- FSM:
  - IDLE -> PKT on an accepted beat with tlast=0.
  - PKT -> IDLE on an accepted beat with tlast=1.
  - A single-beat packet (tlast=1) in IDLE stays in IDLE.
  - busy = (state==PKT).
- m_tuser is always 2'b00 (user-project-to-AS direction requirement).
- Widths: channel slices are extracted by index; no arithmetic on data.

Optional Feature:
- Macro: AXIS_MSTR_MUX_PKT_CNT_EN.
- Defined:
  - Adds output port pkt_cnt (16 bits): count of packets completed on the output, incremented when m_tvalid&m_tready&m_tlast.
  - Wraps 16'hFFFF -> 0; reset to 0.
  - Adds input pkt_cnt_clr (1 bit): synchronous clear, which has priority over increment in the same cycle.
- Undefined: neither port exists and there is no counter logic.

Test Plan:
- Back-to-back, sel=2, m_tready=1:
  - Stimulus: 4-beat packet 0xA0..0xA3 on channel 2.
  - Response: m_tdata A0..A3 on 4 consecutive cycles starting 1 cycle after the first acceptance; tlast on A3; sm_tready=4'b0100.
- Backpressure:
  - Stimulus: m_tready=0 while channel 0 streams 0x11,0x22,0x33.
  - Response: 2 beats accepted, then sm_tready[0]=0; m_tdata holds 0x11. Releasing m_tready yields 0x11,0x22,0x33 in order with no loss.
- Sel change mid-packet:
  - Stimulus: channel 1 sends a 3-beat packet; user_prj_sel goes 1->3 after beat 1.
  - Response: beats 2-3 still from channel 1 and busy=1 until tlast; channel 3 is ready 1 cycle after the tlast acceptance.
- Out-of-range sel:
  - Stimulus: pCH_NUM=4, user_prj_sel=5'd7, all sm_tvalid=1.
  - Response: sm_tready=0, m_tvalid stays 0, m_tuser=2'b00.
- Reset mid-packet:
  - Stimulus: assert axis_rst after 2 of 4 beats, with 1 beat buffered.
  - Response: next cycle m_tvalid=0, busy=0, active_sel=0, and no further beats from the old packet.
- With AXIS_MSTR_MUX_PKT_CNT_EN defined:
  - Stimulus: 3 single-beat packets.
  - Response: pkt_cnt=3; pkt_cnt_clr asserted together with a 4th completion gives 0.
